// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read port and UART line bundle for fifo_uart_tx
interface fifo_uart_tx_if;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    // The UART block drives the pop strobe and the line; the FIFO/host side drives the rest.
    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed UART transmitter; optional even parity bit under FIFO_UART_TX_PARITY_EN
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus_io
);
    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rd_en_q, rd_en_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif
    logic            baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    // State, counters and registered outputs; reset drives the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rd_en_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rd_en_q <= rd_en_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus_io.tx_enable && !bus_io.fifo_empty) begin
                    state_d = FETCH;
                    rd_en_d = 1'b1;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                // FIFO data is valid one cycle after the pop, i.e. during this state.
                shift_d = bus_io.fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^bus_io.fifo_dout;
`endif
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus_io.fifo_rd_en = rd_en_q;
    assign bus_io.tx         = tx_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.frame_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL  = NB * CPB;
    localparam int NR  = 6;
    localparam int TOT = NR * (FL + 3) + 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_uart_tx_if u_if ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (u_if.master)
    );

    always #5 clk = ~clk;

    // FIFO model: registered dout, zeroed when not popped.
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops = 0;
    logic       underflow = 1'b0;
    logic [7:0] dout_q = 8'h00;

    assign u_if.tx_enable  = en;
    assign u_if.fifo_empty = (wr_ptr == rd_ptr);
    assign u_if.fifo_dout  = dout_q;

    always @(posedge clk) begin
        if (u_if.fifo_rd_en) begin
            if (rd_ptr == wr_ptr) underflow <= 1'b1;
            dout_q <= mem[rd_ptr & 255];
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end else begin
            dout_q <= 8'h00;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr & 255] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wire-order frame: bit 0 is the start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '0;
        f[8:1] = b;
`ifdef FIFO_UART_TX_PARITY_EN
        f[9]   = ($countones(b) % 2) == 1;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    // From an idle negedge: wait for the pop, then expect the start bit 2 cycles later.
    task automatic expect_pop_start(input string tag);
        int n;
        n = 0;
        while (!u_if.fifo_rd_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_pop"}, u_if.fifo_rd_en, 1);
        check({tag, "_busy_fetch"}, u_if.busy, 1);
        @(negedge clk);
        check({tag, "_rd_en_pulse"}, u_if.fifo_rd_en, 0);
        check({tag, "_tx_load"}, u_if.tx, 1);
        @(negedge clk);
        check({tag, "_start_latency"}, u_if.tx, 0);
    endtask

    // From the first START cycle: check every bit window, end on the frame_done cycle.
    task automatic expect_bits(input string tag, input logic [10:0] fr);
        logic [3:0] s;
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < CPB; k++) begin
                s[k] = u_if.tx;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, i), s, {4{fr[i]}});
        end
        check({tag, "_frame_done"}, u_if.frame_done, 1);
        check({tag, "_busy_end"}, u_if.busy, 0);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] rb   [NR];
    logic       rec_tx [TOT];
    logic       rec_rd [TOT];
    logic       rec_fd [TOT];
    logic       exp_tx [TOT];
    logic       exp_rd [TOT];
    logic       exp_fd [TOT];

    initial begin
        int cnt;
        int lows;
        int p0;
        int gap;
        int n;
        int mis;
`ifdef FIFO_UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'h54A};
        vecs[1] = '{8'h00, 11'h400};
        vecs[2] = '{8'hFF, 11'h5FE};
        vecs[3] = '{8'h07, 11'h60E};
        vecs[4] = '{8'h03, 11'h406};
        vecs[5] = '{8'h80, 11'h700};
`else
        vecs[0] = '{8'hA5, 11'h34A};
        vecs[1] = '{8'h00, 11'h200};
        vecs[2] = '{8'hFF, 11'h3FE};
        vecs[3] = '{8'h07, 11'h20E};
        vecs[4] = '{8'h03, 11'h206};
        vecs[5] = '{8'h80, 11'h300};
`endif

        // Reset held with data available and enable high.
        en = 1'b1;
        push(8'h00);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (u_if.fifo_rd_en) cnt++;
        end
        check("rst_tx", u_if.tx, 1);
        check("rst_rd_en", u_if.fifo_rd_en, 0);
        check("rst_busy", u_if.busy, 0);
        check("rst_frame_done", u_if.frame_done, 0);
        check("rst_no_pop_strobe", cnt, 0);
        check("rst_pops", pops, 0);

        // Release, then reset again in the middle of DATA (byte 0x00 keeps tx low there).
        rst = 1'b1;
        expect_pop_start("rst_byte");
        repeat (6) @(negedge clk);
        check("mid_data_tx_low", u_if.tx, 0);
        rst = 1'b0;
        #1;
        check("async_rst_tx", u_if.tx, 1);
        check("async_rst_busy", u_if.busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_if.fifo_rd_en) cnt++;
            if (!u_if.tx) lows++;
        end
        check("rst_byte_not_reread", cnt, 0);
        check("rst_pops_once", pops, 1);
        check("rst_after_tx_idle", lows, 0);

        // Table-driven single frames.
        for (int v = 0; v < 6; v++) begin
            p0 = pops;
            push(vecs[v].data);
            expect_pop_start($sformatf("vec%0d", v));
            expect_bits($sformatf("vec%0d", v), vecs[v].frame);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", v), u_if.frame_done, 0);
            check($sformatf("vec%0d_one_pop", v), pops, p0 + 1);
        end

        // Back-to-back 0x00 then 0xFF.
        p0 = pops;
        push(8'h00);
        push(8'hFF);
        expect_pop_start("b2b0");
        expect_bits("b2b0", frame_of(8'h00));
        gap = 0;
        while (u_if.tx && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", gap, 3);
        check("b2b_two_pops", pops, p0 + 2);
        expect_bits("b2b1", frame_of(8'hFF));
        @(negedge clk);

        // Empty FIFO with enable high.
        cnt = 0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (u_if.fifo_rd_en) cnt++;
            if (!u_if.tx) lows++;
        end
        check("empty_no_pop", cnt, 0);
        check("empty_tx_high", lows, 0);

        // Enable drops mid-frame: frame completes, no further pop until re-enabled.
        p0 = pops;
        push(8'h3C);
        push(8'hC3);
        expect_pop_start("dis0");
        en = 1'b0;
        expect_bits("dis0", frame_of(8'h3C));
        cnt = 0;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk);
            if (u_if.fifo_rd_en) cnt++;
        end
        check("dis_no_pop", cnt, 0);
        check("dis_pops", pops, p0 + 1);
        en = 1'b1;
        expect_pop_start("dis1");
        expect_bits("dis1", frame_of(8'hC3));
        @(negedge clk);

        // Random bytes against a timeline model of the whole burst.
        en = 1'b0;
        p0 = pops;
        for (int j = 0; j < NR; j++) begin
            rb[j] = 8'($urandom_range(0, 255));
            push(rb[j]);
        end
        repeat (2) @(negedge clk);
        en = 1'b1;
        n = 0;
        while (!u_if.fifo_rd_en && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rand_first_pop", u_if.fifo_rd_en, 1);
        for (int t = 0; t < TOT; t++) begin
            rec_tx[t] = u_if.tx;
            rec_rd[t] = u_if.fifo_rd_en;
            rec_fd[t] = u_if.frame_done;
            exp_tx[t] = 1'b1;
            exp_rd[t] = 1'b0;
            exp_fd[t] = 1'b0;
            @(negedge clk);
        end
        for (int j = 0; j < NR; j++) begin
            logic [10:0] fr;
            int          base;
            fr   = frame_of(rb[j]);
            base = j * (FL + 3);
            exp_rd[base] = 1'b1;
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < CPB; k++)
                    exp_tx[base + 2 + b * CPB + k] = fr[b];
            exp_fd[base + 2 + FL] = 1'b1;
        end
        for (int j = 0; j <= NR; j++) begin
            int lo;
            int hi;
            lo  = j * (FL + 3);
            hi  = (j == NR) ? TOT : lo + FL + 3;
            mis = 0;
            for (int t = lo; t < hi; t++)
                if (rec_tx[t] !== exp_tx[t] || rec_rd[t] !== exp_rd[t] || rec_fd[t] !== exp_fd[t])
                    mis++;
            check($sformatf("rand_window%0d", j), mis, 0);
        end
        check("rand_pops", pops, p0 + NR);
        check("no_underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
